// File: rtl/control_unit.sv
// control_unit: RV32I main decoder; maps the opcode to datapath control strobes
// and an ALU class, registered with a 1-cycle latency.
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       branch,
    output logic [1:0] aluop,
    output logic       illegal
);
    // {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, aluop, illegal}
    logic [8:0] w_ctrl;
    logic [8:0] r_ctrl;

    always_comb begin
        case (opcode)
            7'b0110011: w_ctrl = 9'b001000100;
            7'b0010011: w_ctrl = 9'b101000110;
            7'b0000011: w_ctrl = 9'b111100000;
            7'b0100011: w_ctrl = 9'b100010000;
            7'b1100011: w_ctrl = 9'b000001010;
            default:    w_ctrl = 9'b000000001;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ctrl <= '0;
        else        r_ctrl <= w_ctrl;
    end

    assign {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, aluop, illegal} = r_ctrl;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the control_unit decode table, latency,
// async reset and strobe invariants across every opcode.
module tb_control_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic       alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, illegal;
    logic [1:0] aluop;
    logic [8:0] w_obs;
    int         checks = 0;
    int         errors = 0;

    localparam logic [8:0] V_ZERO = 9'b000000000;
    localparam logic [8:0] V_R    = 9'b001000100;
    localparam logic [8:0] V_I    = 9'b101000110;
    localparam logic [8:0] V_LD   = 9'b111100000;
    localparam logic [8:0] V_ST   = 9'b100010000;
    localparam logic [8:0] V_BR   = 9'b000001010;
    localparam logic [8:0] V_BAD  = 9'b000000001;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .aluop(aluop), .illegal(illegal)
    );

    assign w_obs = {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, aluop, illegal};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [6:0] op);
        if (op == 7'b0110011) return V_R;
        if (op == 7'b0010011) return V_I;
        if (op == 7'b0000011) return V_LD;
        if (op == 7'b0100011) return V_ST;
        if (op == 7'b1100011) return V_BR;
        return V_BAD;
    endfunction

    // Change opcode mid-cycle: old value must hold until the next edge.
    task automatic apply(input string tag, input logic [6:0] op, input logic [8:0] prev, input logic [8:0] exp);
        opcode = op;
        #1;
        check({tag, "_hold"}, w_obs, prev);
        @(negedge clk);
        check(tag, w_obs, exp);
    endtask

    initial begin
        #1;
        check("reset_async", w_obs, V_ZERO);
        repeat (3) @(negedge clk);
        check("reset_held", w_obs, V_ZERO);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", w_obs, V_R);

        apply("itype", 7'b0010011, V_R, V_I);
        apply("rtype", 7'b0110011, V_I, V_R);
        apply("load", 7'b0000011, V_R, V_LD);
        apply("store", 7'b0100011, V_LD, V_ST);
        apply("branch", 7'b1100011, V_ST, V_BR);
        apply("op_zero", 7'b0000000, V_BR, V_BAD);
        apply("op_ones", 7'b1111111, V_BAD, V_BAD);
        apply("load2", 7'b0000011, V_BAD, V_LD);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", w_obs, V_ZERO);
        opcode = 7'b0010011;
        @(negedge clk);
        check("reset_ignores_op", w_obs, V_ZERO);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", w_obs, V_I);

        for (int k = 0; k < 128; k++) begin
            opcode = 7'(k);
            @(negedge clk);
            check($sformatf("sweep_%0d", k), w_obs, model(7'(k)));
            check($sformatf("inv_rdwr_%0d", k), {8'b0, mem_read & mem_write}, V_ZERO);
            check($sformatf("inv_rw_%0d", k), {8'b0, reg_write & (mem_write | branch)}, V_ZERO);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
